sdram_aref_sched: RTL and testbench
===================================

SDRAM_AREF_SCHED -- requirements
Module: sdram_aref_sched

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 749, meaning clock cycles per refresh credit minus 1 (15 us at 50 MHz).
REQ-002 SHALL have parameter T_RP, default 2, meaning cycles from PRECHARGE to first AREFRESH (range 1..15).
REQ-003 SHALL have parameter T_RFC, default 7, meaning cycles from AREFRESH to the next command or completion (range 1..15).
REQ-004 SHALL have parameter REF_BURST, default 1, meaning maximum AREFRESH commands per grant (range 1..8).
REQ-005 SHALL have parameter MAX_PEND, default 8, meaning refresh-credit saturation limit (range 1..15).
REQ-006 SHALL have parameter URGENT_TH, default 6, meaning credit level that raises ref_urgent.
REQ-007 SHALL have parameter ADDR_W, default 12, meaning SDRAM address width.
REQ-008 CLK  input  1  clock; all logic on rising edge.
REQ-009 RSTn  input  1  reset, asynchronous, active-low.
REQ-010 init_done  input  1  level; SDRAM init sequence complete.
REQ-011 ref_en  input  1  arbiter grant; single-cycle pulse.
REQ-012 ref_req  output  1  refresh request to arbiter.
REQ-013 ref_urgent  output  1  pend_cnt >= URGENT_TH.
REQ-014 ref_busy  output  1  refresh sequence in progress.
REQ-015 flag_ref_end  output  1  one-cycle pulse at sequence completion.
REQ-016 ref_ovf  output  1  sticky; a credit was lost at saturation.
REQ-017 pend_cnt  output  4  outstanding refresh credits.
REQ-018 aref_cmd  output  4  {CS_n,RAS_n,CAS_n,WE_n}; NOP=0111, PRECHARGE=0010, AREFRESH=0001.
REQ-019 sdram_addr  output  ADDR_W  constant; bit 10 = 1 (precharge all banks), all other bits 0.

Function
REQ-020 Interval counter SHALL be held at 0 while init_done=0; otherwise it SHALL count 0..REF_INTERVAL and wrap, producing a one-cycle tick on the wrap cycle.
REQ-021 Each tick SHALL increment pend_cnt; at MAX_PEND, pend_cnt SHALL hold and ref_ovf SHALL set.
REQ-022 Each issued AREFRESH SHALL decrement pend_cnt; a tick coinciding with an AREFRESH SHALL leave pend_cnt unchanged and SHALL NOT set ref_ovf.
REQ-023 ref_req SHALL be registered: 1 when pend_cnt>0 and state=IDLE; otherwise 0. It SHALL drop the cycle after an accepted ref_en.
REQ-024 FSM states SHALL be IDLE, PRE, WAIT_RP, AREF, WAIT_RFC, DONE.
REQ-025 IDLE->PRE SHALL occur on ref_en=1 with ref_req=1; ref_en in any other state or with ref_req=0 SHALL be ignored.
REQ-026 On accepting a grant in cycle g, the sequence SHALL latch burst count N=min(REF_BURST,pend_cnt).
REQ-027 aref_cmd SHALL be registered: PRECHARGE in cycle g+1; AREFRESH in cycle g+1+T_RP; each subsequent AREFRESH T_RFC cycles after the previous one, N in total; NOP in every other cycle.
REQ-028 flag_ref_end SHALL pulse T_RFC cycles after the last AREFRESH, and the FSM SHALL return to IDLE in the same cycle.
REQ-029 ref_busy SHALL be 1 from cycle g+1 through the flag_ref_end cycle inclusive.
REQ-030 init_done falling mid-sequence SHALL NOT abort the sequence; it SHALL only stop credit generation.

Reset
REQ-031 RSTn low SHALL asynchronously force state IDLE, all counters 0, aref_cmd=NOP, and ref_req, ref_urgent, ref_busy, flag_ref_end and ref_ovf to 0, including during an active sequence.

Structure
REQ-032 The command encodings and the FSM state encoding SHALL reside in shared package sdram_pkg, which the init and controller blocks also reuse.
REQ-033 The interval/credit logic SHALL be a sub-module sdram_ref_timer (outputs tick and pend_cnt; inputs init_done and dec).

Verification
REQ-034 Defaults, init_done rising at cycle 0 -> ref_req=1 at cycle 751, pend_cnt=1.
REQ-035 Defaults, ref_en at cycle g -> PRECHARGE at g+1, AREFRESH at g+3, flag_ref_end at g+10, pend_cnt=0 at g+4.
REQ-036 REF_BURST=4, pend_cnt=3 at grant -> exactly 3 AREFRESH commands at g+3, g+10, g+17; flag_ref_end at g+24.
REQ-037 No grant for 9 intervals -> pend_cnt=8, ref_urgent=1 from pend_cnt=6, ref_ovf=1 after the 9th tick.
REQ-038 Tick coincident with AREFRESH at pend_cnt=2 -> pend_cnt stays 2; ref_en pulsed while busy -> no effect.
REQ-039 RSTn asserted at g+5 -> aref_cmd=NOP and state IDLE immediately; no flag_ref_end after release.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings and refresh FSM states shared by init, refresh and controller blocks.
package sdram_pkg;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_WAIT_RP, ST_AREF, ST_WAIT_RFC, ST_DONE} ref_state_e;
  function automatic logic [3:0] min_u4(input logic [3:0] a, input logic [3:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: refresh interval counter and saturating credit counter.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 749,
  parameter int MAX_PEND     = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       init_done,
  input  logic       dec,
  output logic       tick,
  output logic [3:0] pend_cnt
);
  localparam int CW = (REF_INTERVAL > 0) ? $clog2(REF_INTERVAL + 1) : 1;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pend;
  assign tick     = init_done && (r_cnt == CW'(REF_INTERVAL));
  assign pend_cnt = r_pend;
  // A tick and a decrement in the same cycle cancel out.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      r_cnt <= (!init_done || tick) ? '0 : r_cnt + 1'b1;
      if (tick && !dec && r_pend != 4'(MAX_PEND))
        r_pend <= r_pend + 1'b1;
      else if (dec && !tick && r_pend != '0)
        r_pend <= r_pend - 1'b1;
    end
  end
endmodule

// File: rtl/sdram_aref_sched.sv
// sdram_aref_sched: auto-refresh scheduler; requests a grant, then issues PRECHARGE-all plus a burst of AREFRESH.
module sdram_aref_sched import sdram_pkg::*; #(
  parameter int REF_INTERVAL = 749,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int REF_BURST    = 1,
  parameter int MAX_PEND     = 8,
  parameter int URGENT_TH    = 6,
  parameter int ADDR_W       = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              init_done,
  input  logic              ref_en,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic              ref_busy,
  output logic              flag_ref_end,
  output logic              ref_ovf,
  output logic [3:0]        pend_cnt,
  output logic [3:0]        aref_cmd,
  output logic [ADDR_W-1:0] sdram_addr
);
  ref_state_e r_state, w_nxt;
  logic [3:0] r_wait, r_left, r_cmd;
  logic       r_req, r_busy, r_flag, r_ovf;
  logic       w_tick, w_dec, w_grant;
  assign w_dec        = r_cmd == CMD_AREF;
  assign w_grant      = r_state == ST_IDLE && ref_en && r_req;
  assign aref_cmd     = r_cmd;
  assign ref_req      = r_req;
  assign ref_busy     = r_busy;
  assign flag_ref_end = r_flag;
  assign ref_ovf      = r_ovf;
  assign ref_urgent   = pend_cnt >= 4'(URGENT_TH);
  assign sdram_addr   = ADDR_W'(1) << 10;
  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL), .MAX_PEND(MAX_PEND)) u_timer (
    .CLK(CLK), .RSTn(RSTn), .init_done(init_done), .dec(w_dec), .tick(w_tick), .pend_cnt(pend_cnt)
  );
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:              w_nxt = w_grant ? ST_PRE : ST_IDLE;
      ST_PRE, ST_WAIT_RP:   w_nxt = (r_wait == 4'(T_RP - 1)) ? ST_AREF : ST_WAIT_RP;
      ST_AREF, ST_WAIT_RFC: w_nxt = (r_wait != 4'(T_RFC - 1)) ? ST_WAIT_RFC : (r_left == '0) ? ST_DONE : ST_AREF;
      default:              w_nxt = ST_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_left  <= '0;
      r_cmd   <= CMD_NOP;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= (w_nxt == ST_PRE || w_nxt == ST_AREF) ? '0 : r_wait + 1'b1;
      r_left  <= w_grant ? min_u4(4'(REF_BURST), pend_cnt) : (w_nxt == ST_AREF) ? r_left - 1'b1 : r_left;
      r_cmd   <= (w_nxt == ST_PRE) ? CMD_PRE : (w_nxt == ST_AREF) ? CMD_AREF : CMD_NOP;
      r_req   <= w_nxt == ST_IDLE && pend_cnt != '0;
      r_busy  <= w_nxt != ST_IDLE;
      r_flag  <= w_nxt == ST_DONE;
      r_ovf   <= r_ovf | (w_tick && !w_dec && pend_cnt == 4'(MAX_PEND));
    end
  end
endmodule

// File: tb/tb_sdram_aref_sched.sv
// tb_sdram_aref_sched: scoreboard bench; stimulus queues expected commands, a negedge monitor checks them.
module tb_sdram_aref_sched;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        init_done = 1'b0;
  logic        ref_en = 1'b0;
  logic        ref_req, ref_urgent, ref_busy, flag_ref_end, ref_ovf;
  logic [3:0]  pend_cnt, aref_cmd;
  logic [11:0] sdram_addr;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0, g;
  typedef struct {int cyc; logic [3:0] cmd; logic flag;} ev_t;
  ev_t sb[$];

  sdram_aref_sched #(.REF_BURST(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .init_done(init_done), .ref_en(ref_en),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_busy(ref_busy),
    .flag_ref_end(flag_ref_end), .ref_ovf(ref_ovf), .pend_cnt(pend_cnt),
    .aref_cmd(aref_cmd), .sdram_addr(sdram_addr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (aref_cmd != 4'b0111 || flag_ref_end) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cmd=%b flag=%0d at cycle %0d, none expected", aref_cmd, flag_ref_end, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.cmd != aref_cmd || e.flag != flag_ref_end) begin
          fails++;
          $display("FAIL event: got cmd=%b flag=%0d at cycle %0d, expected cmd=%b flag=%0d at cycle %0d",
                   aref_cmd, flag_ref_end, cyc, e.cmd, e.flag, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] cmd, input logic flag);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.flag = flag;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_en(input int c);
    goto(c);
    ref_en = 1'b1;
    goto(c + 1);
    ref_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cmd", aref_cmd, 4'b0111);
    chk("rst_req", ref_req, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("addr", sdram_addr, 12'h400);
    RSTn = 1'b1;
    goto(cyc + 100);
    chk("no_init_pend", pend_cnt, 0);
    c0 = cyc + 1;
    goto(c0);
    init_done = 1'b1;
    // first credit
    goto(c0 + 750);
    chk("req_750", ref_req, 0);
    chk("pend_750", pend_cnt, 1);
    goto(c0 + 751);
    chk("req_751", ref_req, 1);
    chk("pend_751", pend_cnt, 1);
    // single refresh, ref_en while busy ignored
    g = c0 + 760;
    push(g + 1, 4'b0010, 1'b0);
    push(g + 3, 4'b0001, 1'b0);
    push(g + 10, 4'b0111, 1'b1);
    pulse_en(g);
    chk("busy_g1", ref_busy, 1);
    chk("req_g1", ref_req, 0);
    goto(g + 3);
    chk("pend_g3", pend_cnt, 1);
    goto(g + 4);
    chk("pend_g4", pend_cnt, 0);
    pulse_en(g + 5);
    goto(g + 10);
    chk("busy_g10", ref_busy, 1);
    goto(g + 11);
    chk("busy_g11", ref_busy, 0);
    // tick coincident with first AREFRESH at pend_cnt=2
    g = c0 + 2996;
    push(g + 1, 4'b0010, 1'b0);
    push(g + 3, 4'b0001, 1'b0);
    push(g + 10, 4'b0001, 1'b0);
    push(g + 17, 4'b0111, 1'b1);
    goto(g);
    chk("pend_pre_coinc", pend_cnt, 2);
    pulse_en(g);
    goto(g + 4);
    chk("pend_coinc", pend_cnt, 2);
    chk("ovf_coinc", ref_ovf, 0);
    pulse_en(g + 6);
    goto(g + 11);
    chk("pend_coinc_g11", pend_cnt, 1);
    // burst of 3 with REF_BURST=4
    g = c0 + 4510;
    push(g + 1, 4'b0010, 1'b0);
    push(g + 3, 4'b0001, 1'b0);
    push(g + 10, 4'b0001, 1'b0);
    push(g + 17, 4'b0001, 1'b0);
    push(g + 24, 4'b0111, 1'b1);
    goto(g);
    chk("pend_burst", pend_cnt, 3);
    pulse_en(g);
    goto(g + 18);
    chk("pend_burst_g18", pend_cnt, 0);
    goto(g + 25);
    chk("busy_burst_end", ref_busy, 0);
    // saturation over 9 intervals
    goto(c0 + 8250);
    chk("pend_5", pend_cnt, 5);
    chk("urg_5", ref_urgent, 0);
    goto(c0 + 9000);
    chk("pend_6", pend_cnt, 6);
    chk("urg_6", ref_urgent, 1);
    goto(c0 + 10500);
    chk("pend_8", pend_cnt, 8);
    chk("ovf_8", ref_ovf, 0);
    goto(c0 + 11250);
    chk("pend_sat", pend_cnt, 8);
    chk("ovf_sat", ref_ovf, 1);
    // async reset mid-sequence
    g = c0 + 11260;
    push(g + 1, 4'b0010, 1'b0);
    push(g + 3, 4'b0001, 1'b0);
    pulse_en(g);
    goto(g + 4);
    chk("pend_pre_rst", pend_cnt, 7);
    goto(g + 5);
    RSTn = 1'b0;
    #1;
    chk("rst_mid_cmd", aref_cmd, 4'b0111);
    chk("rst_mid_busy", ref_busy, 0);
    chk("rst_mid_pend", pend_cnt, 0);
    chk("rst_mid_ovf", ref_ovf, 0);
    chk("rst_mid_urg", ref_urgent, 0);
    goto(g + 8);
    RSTn = 1'b1;
    goto(g + 40);
    chk("post_rst_busy", ref_busy, 0);
    chk("post_rst_req", ref_req, 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
